// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the single-cycle ALU result (port A) and the
// buffered multi-cycle result (port B) onto the register file write port.
// Port A always wins. Port B waits in a small FIFO. A younger A write kills
// older queued B writes to the same register. Pending-write queries let the
// issue logic stall on registers that still have writes queued or in flight.
module regfile_wb_arbiter #(
  parameter int DEPTH  = 4,
  parameter int STARVE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [4:0]             a_wa,
  input  logic [31:0]            a_wd,
  output logic                   a_stall,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [4:0]             b_wa,
  input  logic [31:0]            b_wd,
  input  logic [4:0]             q_ra1,
  input  logic [4:0]             q_ra2,
  output logic                   q_pend1,
  output logic                   q_pend2,
  output logic                   we,
  output logic [4:0]             wa,
  output logic [31:0]            wd,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE + 1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);
  localparam logic [SW-1:0] STARVE_ZERO = {SW{1'b0}};

  // FIFO storage; live_r marks occupied entries that have not been killed
  logic [4:0]       ent_wa_r [DEPTH];
  logic [31:0]      ent_wd_r [DEPTH];
  logic [DEPTH-1:0] live_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [SW-1:0]    starve_r;
  logic [SW-1:0]    starve_nxt_s;
  logic             a_win_s;
  logic             push_s;
  logic             pop_s;
  logic             head_live_s;
  logic             empty_s;

  // Decode arbitration winner and the FIFO push/pop handshakes
  always_comb begin
    empty_s     = (count == CNT_ZERO);
    b_ready     = (count != CNT_FULL);
    a_win_s     = a_valid && (a_wa != 5'd0);
    push_s      = b_valid && b_ready && (b_wa != 5'd0);
    pop_s       = !a_win_s && !empty_s;
    head_live_s = live_r[head_r];
  end

  // Next value of the starvation counter (saturates at STARVE)
  always_comb begin
    starve_nxt_s = starve_r;
    if (empty_s || pop_s) begin
      starve_nxt_s = STARVE_ZERO;
    end else if (head_live_s && a_win_s) begin
      if (starve_r == STARVE_MAX) begin
        starve_nxt_s = STARVE_MAX;
      end else begin
        starve_nxt_s = starve_r + STARVE_ONE;
      end
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Pending-write lookup over live FIFO entries and the write in flight
  always_comb begin
    q_pend1 = we && (wa == q_ra1);
    q_pend2 = we && (wa == q_ra2);
    for (int i = 0; i < DEPTH; i++) begin
      q_pend1 = q_pend1 || (live_r[i] && (ent_wa_r[i] == q_ra1));
      q_pend2 = q_pend2 || (live_r[i] && (ent_wa_r[i] == q_ra2));
    end
    q_pend1 = q_pend1 && (q_ra1 != 5'd0);
    q_pend2 = q_pend2 && (q_ra2 != 5'd0);
  end

  // Write port, FIFO state, kill marking and starvation tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      we       <= 1'b0;
      wa       <= 5'd0;
      wd       <= 32'd0;
      a_stall  <= 1'b0;
      count    <= CNT_ZERO;
      head_r   <= {PW{1'b0}};
      tail_r   <= {PW{1'b0}};
      live_r   <= {DEPTH{1'b0}};
      starve_r <= STARVE_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        ent_wa_r[i] <= 5'd0;
        ent_wd_r[i] <= 32'd0;
      end
    end else begin
      if (a_win_s) begin
        we <= 1'b1;
        wa <= a_wa;
        wd <= a_wd;
      end else if (pop_s && head_live_s) begin
        we <= 1'b1;
        wa <= ent_wa_r[head_r];
        wd <= ent_wd_r[head_r];
      end else begin
        we <= 1'b0;
      end

      // An accepted A write supersedes older queued writes to the same register
      for (int i = 0; i < DEPTH; i++) begin
        if (a_win_s && live_r[i] && (ent_wa_r[i] == a_wa)) begin
          live_r[i] <= 1'b0;
        end
      end

      if (pop_s) begin
        live_r[head_r] <= 1'b0;
        head_r         <= head_r + PTR_ONE;
      end

      if (push_s) begin
        ent_wa_r[tail_r] <= b_wa;
        ent_wd_r[tail_r] <= b_wd;
        live_r[tail_r]   <= 1'b1;
        tail_r           <= tail_r + PTR_ONE;
      end

      case ({push_s, pop_s})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      starve_r <= starve_nxt_s;
      a_stall  <= (starve_nxt_s == STARVE_MAX);
    end
  end

  regfile_wb_arbiter_chk #(.DEPTH(DEPTH)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_stall (a_stall),
    .b_ready (b_ready),
    .we      (we),
    .wa      (wa),
    .count   (count)
  );
endmodule

// regfile_wb_arbiter_chk: protocol and invariant checks for the arbiter
module regfile_wb_arbiter_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   a_valid,
  input logic                   a_stall,
  input logic                   b_ready,
  input logic                   we,
  input logic [4:0]             wa,
  input logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;

  a_valid_held_during_stall: assert property (@(posedge clk) disable iff (rst)
    !(a_stall && a_valid));

  no_write_to_r0: assert property (@(posedge clk) disable iff (rst)
    !(we && (wa == 5'd0)));

  count_in_range: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));

  ready_tracks_count: assert property (@(posedge clk) disable iff (rst)
    b_ready == (count != CW'(DEPTH)));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: randomized and directed stimulus. A queue-level
// reference model predicts every register file write. Predicted writes go into
// a scoreboard queue, and a negedge monitor checks them against the DUT.
module tb_regfile_wb_arbiter;
  localparam int DEPTH  = 4;
  localparam int STARVE = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   a_valid;
  logic [4:0]             a_wa;
  logic [31:0]            a_wd;
  logic                   a_stall;
  logic                   b_valid;
  logic                   b_ready;
  logic [4:0]             b_wa;
  logic [31:0]            b_wd;
  logic [4:0]             q_ra1;
  logic [4:0]             q_ra2;
  logic                   q_pend1;
  logic                   q_pend2;
  logic                   we;
  logic [4:0]             wa;
  logic [31:0]            wd;
  logic [$clog2(DEPTH):0] count;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_stall(a_stall),
    .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .q_pend1(q_pend1), .q_pend2(q_pend2),
    .we(we), .wa(wa), .wd(wd), .count(count)
  );

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    bit          live;
  } ent_t;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
    int          cyc;
  } exp_t;

  // Reference model: FIFO contents as a queue plus the visible write port
  ent_t        mq[$];
  exp_t        exp_q[$];
  int          mstarve = 0;
  bit          mstall  = 1'b0;
  bit          mwe     = 1'b0;
  logic [4:0]  mwa     = 5'd0;
  logic [31:0] mwd     = 32'd0;

  // Expected values for the cycle currently on the pins
  int          e_count;
  bit          e_ready, e_stall, e_p1, e_p2;
  logic [4:0]  e_wa;
  logic [31:0] e_wd;

  bit   checking = 1'b0;
  int   cyc      = 0;
  int   tests    = 0;
  int   fails    = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit pend(input logic [4:0] q);
    if (q == 5'd0) return 1'b0;
    if (mwe && (mwa == q)) return 1'b1;
    foreach (mq[i]) begin
      if (mq[i].live && (mq[i].wa == q)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Snapshot expectations, advance the model by one clock, then step the clock
  task automatic cycle_go();
    bit   a_win, push, popped, hlive;
    int   sz;
    ent_t h;
    if (mstall) a_valid = 1'b0;
    e_count = mq.size();
    e_ready = (mq.size() != DEPTH);
    e_stall = mstall;
    e_wa    = mwa;
    e_wd    = mwd;
    e_p1    = pend(q_ra1);
    e_p2    = pend(q_ra2);
    if (rst) begin
      mq.delete();
      mstarve = 0;
      mstall  = 1'b0;
      mwe     = 1'b0;
      mwa     = 5'd0;
      mwd     = 32'd0;
    end else begin
      sz     = mq.size();
      a_win  = a_valid && (a_wa != 5'd0);
      push   = b_valid && (sz != DEPTH) && (b_wa != 5'd0);
      hlive  = (sz > 0) && mq[0].live;
      popped = 1'b0;
      mwe    = 1'b0;
      if (a_win) begin
        mwe = 1'b1;
        mwa = a_wa;
        mwd = a_wd;
        foreach (mq[i]) if (mq[i].wa == a_wa) mq[i].live = 1'b0;
      end else if (sz > 0) begin
        h = mq.pop_front();
        popped = 1'b1;
        if (h.live) begin
          mwe = 1'b1;
          mwa = h.wa;
          mwd = h.wd;
        end
      end
      if (mwe) exp_q.push_back('{wa: mwa, wd: mwd, cyc: cyc + 1});
      if (sz == 0 || popped) mstarve = 0;
      else if (hlive && a_win) mstarve = (mstarve < STARVE) ? mstarve + 1 : STARVE;
      mstall = (mstarve == STARVE);
      if (push) mq.push_back('{wa: b_wa, wd: b_wd, live: 1'b1});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst     = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_wa    = 5'($urandom_range(0, 31));
    a_wd    = $urandom;
    b_wa    = 5'($urandom_range(0, 31));
    b_wd    = $urandom;
    q_ra1   = 5'($urandom_range(0, 31));
    q_ra2   = 5'($urandom_range(0, 31));
  endtask

  // Monitor: compares the pins against the model and the write scoreboard
  always @(negedge clk) begin
    if (checking) begin
      chk("count", 32'(count), 32'(e_count));
      chk("b_ready", 32'(b_ready), 32'(e_ready));
      chk("a_stall", 32'(a_stall), 32'(e_stall));
      chk("q_pend1", 32'(q_pend1), 32'(e_p1));
      chk("q_pend2", 32'(q_pend2), 32'(e_p2));
      if (we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_we", 32'(we), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_wa", 32'(wa), 32'(mon_e.wa));
          chk("write_wd", wd, mon_e.wd);
          chk("write_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else begin
        chk("missing_write_we", 32'(we),
            32'((exp_q.size() > 0) && (exp_q[0].cyc == cyc)));
        chk("hold_wa", 32'(wa), 32'(e_wa));
        chk("hold_wd", wd, e_wd);
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    checking = 1'b1;
    rst = 1'b1;
    cycle_go();

    // Single B write with an empty FIFO and no A traffic
    idle();
    b_valid = 1'b1; b_wa = 5'd5; b_wd = 32'hDEADBEEF; q_ra1 = 5'd5;
    cycle_go();
    for (int i = 0; i < 4; i++) begin idle(); q_ra1 = 5'd5; cycle_go(); end

    // A every cycle starves the head until a_stall forces a gap
    for (int i = 0; i < 14; i++) begin
      idle();
      a_valid = 1'b1; a_wa = 5'(16 + i); a_wd = $urandom;
      b_valid = (i < 2); b_wa = 5'(9 + i); b_wd = $urandom;
      q_ra1 = 5'd9; q_ra2 = 5'd10;
      cycle_go();
    end
    for (int i = 0; i < 4; i++) begin idle(); cycle_go(); end

    // Fill the FIFO while A is active, then push and pop together
    for (int i = 0; i < 10; i++) begin
      idle();
      a_valid = 1'b1; a_wa = 5'($urandom_range(1, 31));
      b_valid = 1'b1; b_wa = 5'($urandom_range(1, 31));
      cycle_go();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); b_valid = 1'b1; b_wa = 5'($urandom_range(1, 31)); cycle_go();
    end
    for (int i = 0; i < 6; i++) begin idle(); cycle_go(); end

    // Younger A write to r7 kills the queued B write to r7
    idle();
    a_valid = 1'b1; a_wa = 5'd3; b_valid = 1'b1; b_wa = 5'd7; b_wd = 32'h11; q_ra1 = 5'd7;
    cycle_go();
    idle();
    a_valid = 1'b1; a_wa = 5'd7; a_wd = 32'h22; q_ra1 = 5'd7;
    cycle_go();
    for (int i = 0; i < 4; i++) begin idle(); q_ra1 = 5'd7; cycle_go(); end

    // Reset with three entries queued and a write in flight
    for (int i = 0; i < 4; i++) begin
      idle();
      a_valid = 1'b1; a_wa = 5'(20 + i);
      b_valid = (i < 3); b_wa = 5'(1 + i);
      cycle_go();
    end
    idle(); rst = 1'b1; a_valid = 1'b1; a_wa = 5'd25; cycle_go();
    for (int i = 0; i < 4; i++) begin idle(); cycle_go(); end

    // Random traffic with frequent r0 addresses and occasional reset
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 50; i++) begin
        idle();
        rst     = ($urandom_range(0, 99) == 0);
        a_valid = ($urandom_range(0, 9) < ((blk % 2 == 0) ? 9 : 4));
        a_wa    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        b_valid = ($urandom_range(0, 1) == 1);
        b_wa    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        if ($urandom_range(0, 3) == 0) q_ra1 = 5'd0;
        cycle_go();
      end
    end

    for (int i = 0; i < 20; i++) begin idle(); cycle_go(); end
    checking = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
